uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
// - Serial-to-register-bus bridge: receives 8N1 command frames on rx_i and issues single-cycle
//   pwrite/pread transactions on the peripheral register bus (same bus uart_core responds on).
// - Returns read data / write ack on tx_o. Lets a host PC poke any peripheral with no CPU present.
// PARAMETERS
// - CLKS_PER_BIT   868  pclk cycles per serial bit (100 MHz / 115200); legal >= 8
// - READ_LAT       1    cycles from pread_o high to prdata_i valid (registered responder = 1)
// - TIMEOUT_BITS   40   idle bit-times tolerated mid-command (only with UART_BUS_TIMEOUT_EN)
// PORTS
// - pclk_i     in   1   clock, all logic rising-edge
// - prst_ni    in   1   reset, asynchronous, active-low
// - rx_i       in   1   serial input from host, idle high, async (2-flop synchronised inside)
// - tx_o       out  1   serial output to host, idle high
// - paddr_o    out  12  bus address
// - pwdata_o   out  32  bus write data
// - pwrite_o   out  1   bus write strobe, one-cycle pulse
// - pread_o    out  1   bus read strobe, one-cycle pulse
// - prdata_i   in   32  bus read data, sampled READ_LAT cycles after pread_o
// - busy_o     out  1   high from first cmd byte accepted until last response stop bit sent
// - err_o      out  1   one-cycle pulse: framing error, bad opcode, or timeout
// BEHAVIOUR
// - Reset (async assert, sync release): tx_o=1, pwrite_o=0, pread_o=0, paddr_o=0, pwdata_o=0,
//   busy_o=0, err_o=0, FSM=IDLE, all counters 0.
// - RX: falling edge on synchronised rx -> wait CLKS_PER_BIT/2, start must still be 0 else
//   discard (glitch, no err). 8 data bits LSB first at CLKS_PER_BIT spacing, then stop bit.
//   Stop=0 -> framing error: err_o pulse, byte dropped, FSM -> IDLE. Good byte -> rx_vld 1 cycle.
// - TX: 8N1, LSB first, start bit begins cycle after load; bytes back-to-back, no gap bits.
// - Frame: opcode, ADDR_HI, ADDR_LO (paddr_o = {ADDR_HI[3:0],ADDR_LO}; ADDR_HI[7:4] ignored),
//   then for write D3 D2 D1 D0 (MSB first). Opcodes: 0x57 'W' write, 0x52 'R' read.
// - FSM: IDLE -> ADDR (2 bytes) -> WDATA (4 bytes, W only) -> BUS_WR | BUS_RD -> RD_WAIT -> RESP -> IDLE.
//   IDLE: other opcode -> err_o pulse, reply 0x45 'E', stay request-free.
//   BUS_WR: last data byte rx_vld at cycle N -> pwrite_o=1 at N+1 only; RESP sends 0x4B 'K',
//     start bit at N+2.
//   BUS_RD: last addr byte rx_vld at N -> pread_o=1 at N+1; prdata_i captured at N+1+READ_LAT;
//     RESP sends 4 bytes MSB first, start bit next cycle.
// - paddr_o/pwdata_o update only when the bus phase is entered, held until the next command;
//   never change in the cycle pwrite_o/pread_o is high.
// - pwrite_o and pread_o never high together; at most one strobe per command.
// - Bytes received while in RESP are dropped silently (host must wait for response).
// - Byte counter 3 bits, cleared on every IDLE entry; no wrap possible (max 4).
// - Framing error mid-command: abort, no bus access, no response, busy_o=0 next cycle.
// - Reset mid-TX: tx_o returns to 1 immediately (async); partial byte lost.
// CONFIGURATION
// - UART_BUS_TIMEOUT_EN defined: bit-time counter runs in ADDR/WDATA, cleared on each rx_vld;
//   reaching TIMEOUT_BITS bit-times -> err_o pulse, FSM -> IDLE, no bus access, no response.
// - Not defined: no timeout logic; FSM waits indefinitely for remaining bytes.
// TESTING (CLKS_PER_BIT=16, READ_LAT=1)
// - Send 57 00 0C 00 00 00 01 -> one pwrite_o, paddr_o=0x00C, pwdata_o=0x00000001; tx returns 0x4B.
// - Send 52 00 08, responder drives prdata_i=0xA5C3_1E77 -> one pread_o, paddr_o=0x008;
//   tx returns A5 C3 1E 77.
// - Send opcode 0x13 -> err_o pulse, tx returns 0x45, no bus strobe.
// - Send 57 01 with stop bit forced 0 on 2nd byte -> err_o pulse, no response, busy_o drops.
// - With UART_BUS_TIMEOUT_EN: send 52 00 then idle 41 bit-times -> err_o, IDLE; then 52 00 08 works.
// - Assert prst_ni low mid-response byte -> tx_o=1, busy_o=0 immediately; next command works.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master
//   Serial-to-register-bus bridge. Receives 8N1 command frames from a host
//   and issues single-cycle write/read strobes on the peripheral register bus.
//   The reply goes back on tx_o: 'K' after a write, the four read-data bytes
//   (MSB first) after a read, or 'E' for an unknown opcode.
//   Frames: 'W'(0x57) AH AL D3 D2 D1 D0  |  'R'(0x52) AH AL ; addr = {AH[3:0],AL}
// Ports
//   pclk_i, prst_ni     clock (rising edge), asynchronous active-low reset
//   rx_i / tx_o         serial from / to host, idle high
//   paddr_o, pwdata_o   bus address / write data, held until the next command
//   pwrite_o, pread_o   one-cycle bus strobes
//   prdata_i            read data, valid READ_LAT cycles after pread_o
//   busy_o              first command byte accepted .. last reply stop bit done
//   err_o               one-cycle pulse: framing error, bad opcode or timeout
// Configuration macro
//   UART_BUS_TIMEOUT_EN  abort a command idle for TIMEOUT_BITS bit-times
module uart_bus_master #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        pclk_i,
  input  logic        prst_ni,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [11:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o,
  output logic        pread_o,
  input  logic [31:0] prdata_i,
  output logic        busy_o,
  output logic        err_o
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    LAT_END  = 8'(READ_LAT - 1);
  localparam logic [7:0]    OP_WR    = 8'h57;
  localparam logic [7:0]    OP_RD    = 8'h52;
  localparam logic [7:0]    RSP_ACK  = 8'h4B;
  localparam logic [7:0]    RSP_ERR  = 8'h45;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, RESP} state_t;

  rx_state_t     rx_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh, rx_byte;
  logic          rx_vld, rx_ferr;

  logic          tx_active, tx_ld, tx_done;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_left;
  logic [8:0]    tx_sh;
  logic [7:0]    tx_byte;

  state_t        state;
  logic          is_wr, tmo_hit;
  logic [2:0]    byte_cnt;
  logic [3:0]    addr_hi;
  logic [11:0]   addr_q;
  logic [23:0]   wdata_q;
  logic [31:0]   resp_buf;
  logic [1:0]    resp_left;
  logic [7:0]    lat_cnt;

  // Receiver: start is re-checked at mid-bit, data sampled at mid-bit.
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE:
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        RX_START:
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA:
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP:
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_vld  <= 1'b1;
              rx_byte <= rx_sh;
            end else rx_ferr <= 1'b1;
          end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: a load in the last cycle of a stop bit chains the next
  // start bit with no idle gap.
  assign tx_done = tx_active && (tx_cnt == BIT_END) && (tx_left == 4'd0);

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      tx_o      <= 1'b1;
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_left   <= '0;
      tx_sh     <= '1;
    end else if (tx_ld) begin
      tx_o      <= 1'b0;
      tx_sh     <= {1'b1, tx_byte};
      tx_cnt    <= '0;
      tx_left   <= 4'd9;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (tx_cnt == BIT_END) begin
        tx_cnt <= '0;
        if (tx_left == 4'd0) tx_active <= 1'b0;
        else begin
          tx_o    <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_left <= tx_left - 1'b1;
        end
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // Reply bytes are launched combinationally from the FSM state so the start
  // bit lands one cycle after the bus strobe / read capture.
  always_comb begin
    tx_ld   = 1'b0;
    tx_byte = '0;
    case (state)
      IDLE:
        if (rx_vld && rx_byte != OP_WR && rx_byte != OP_RD) begin
          tx_ld   = 1'b1;
          tx_byte = RSP_ERR;
        end
      BUS_WR: begin
        tx_ld   = 1'b1;
        tx_byte = RSP_ACK;
      end
      RD_WAIT:
        if (lat_cnt == LAT_END) begin
          tx_ld   = 1'b1;
          tx_byte = prdata_i[31:24];
        end
      RESP:
        if (tx_done && resp_left != 2'd0) begin
          tx_ld   = 1'b1;
          tx_byte = resp_buf[31:24];
        end
      default: ;
    endcase
  end

`ifdef UART_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);
  logic [CW-1:0] tmo_clk;
  logic [TW-1:0] tmo_bits;

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      tmo_clk  <= '0;
      tmo_bits <= '0;
    end else if ((state == ADDR || state == WDATA) && !rx_vld) begin
      if (tmo_clk == BIT_END) begin
        tmo_clk  <= '0;
        tmo_bits <= tmo_bits + 1'b1;
      end else tmo_clk <= tmo_clk + 1'b1;
    end else begin
      tmo_clk  <= '0;
      tmo_bits <= '0;
    end
  end

  assign tmo_hit = (tmo_bits == TW'(TIMEOUT_BITS));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      byte_cnt  <= '0;
      addr_hi   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      lat_cnt   <= '0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      pread_o   <= 1'b0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      pwrite_o <= 1'b0;
      pread_o  <= 1'b0;
      err_o    <= 1'b0;
      if (rx_ferr && (state == IDLE || state == ADDR || state == WDATA)) begin
        err_o    <= 1'b1;
        state    <= IDLE;
        busy_o   <= 1'b0;
        byte_cnt <= '0;
      end else if (tmo_hit && !rx_vld && (state == ADDR || state == WDATA)) begin
        err_o    <= 1'b1;
        state    <= IDLE;
        busy_o   <= 1'b0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE:
            if (rx_vld) begin
              busy_o   <= 1'b1;
              byte_cnt <= '0;
              is_wr    <= (rx_byte == OP_WR);
              if (rx_byte == OP_WR || rx_byte == OP_RD) state <= ADDR;
              else begin
                err_o     <= 1'b1;
                resp_left <= '0;
                state     <= RESP;
              end
            end
          ADDR:
            if (rx_vld) begin
              if (byte_cnt == 3'd0) begin
                addr_hi  <= rx_byte[3:0];
                byte_cnt <= 3'd1;
              end else begin
                byte_cnt <= '0;
                if (is_wr) begin
                  addr_q <= {addr_hi, rx_byte};
                  state  <= WDATA;
                end else begin
                  paddr_o <= {addr_hi, rx_byte};
                  pread_o <= 1'b1;
                  state   <= BUS_RD;
                end
              end
            end
          WDATA:
            if (rx_vld) begin
              wdata_q  <= {wdata_q[15:0], rx_byte};
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == 3'd3) begin
                paddr_o  <= addr_q;
                pwdata_o <= {wdata_q, rx_byte};
                pwrite_o <= 1'b1;
                state    <= BUS_WR;
              end
            end
          BUS_WR: begin
            resp_left <= '0;
            state     <= RESP;
          end
          BUS_RD: begin
            lat_cnt <= '0;
            state   <= RD_WAIT;
          end
          RD_WAIT:
            if (lat_cnt == LAT_END) begin
              resp_buf  <= {prdata_i[23:0], 8'h00};
              resp_left <= 2'd3;
              state     <= RESP;
            end else lat_cnt <= lat_cnt + 1'b1;
          RESP:
            if (tx_done) begin
              if (resp_left != 2'd0) begin
                resp_buf  <= {resp_buf[23:0], 8'h00};
                resp_left <= resp_left - 1'b1;
              end else begin
                state    <= IDLE;
                busy_o   <= 1'b0;
                byte_cnt <= '0;
              end
            end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
module tb_uart_bus_master;
  localparam int CPB = 16;

  logic        pclk_i  = 1'b0;
  logic        prst_ni = 1'b0;
  logic        rx_i    = 1'b1;
  logic        tx_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        pread_o;
  logic [31:0] prdata_i;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] rd_val = 32'h0;
  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_starts = 0;
  logic [11:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  int          wr_cyc = 0, rd_cyc = 0;
  int          m_state = 0, m_cnt = 0;
  logic [7:0]  m_sh = '0;
  logic [7:0]  m_exp;
  bit          mark_start = 1'b0;
  int          start_cyc = 0;

  uart_bus_master #(
    .CLKS_PER_BIT(CPB),
    .READ_LAT    (1),
    .TIMEOUT_BITS(40)
  ) dut (
    .pclk_i  (pclk_i),
    .prst_ni (prst_ni),
    .rx_i    (rx_i),
    .tx_o    (tx_o),
    .paddr_o (paddr_o),
    .pwdata_o(pwdata_o),
    .pwrite_o(pwrite_o),
    .pread_o (pread_o),
    .prdata_i(prdata_i),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 pclk_i = ~pclk_i;

  always @(posedge pclk_i) cyc <= cyc + 1;

  // Registered responder: data valid exactly one cycle after pread_o.
  always @(posedge pclk_i or negedge prst_ni)
    if (!prst_ni) prdata_i <= 32'hDEAD_BEEF;
    else          prdata_i <= pread_o ? rd_val : 32'hDEAD_BEEF;

  // Bus monitor.
  always @(negedge pclk_i) begin
    if (prst_ni) begin
      if (pwrite_o || pread_o) begin
        checks++;
        if (pwrite_o && pread_o) begin
          errors++;
          $display("FAIL strobe_excl: pwrite_o=%b pread_o=%b, required not both high", pwrite_o, pread_o);
        end
      end
      if (pwrite_o) begin wr_cnt++; wr_addr = paddr_o; wr_data = pwdata_o; wr_cyc = cyc; end
      if (pread_o)  begin rd_cnt++; rd_addr = paddr_o; rd_cyc = cyc; end
      if (err_o) err_cnt++;
    end
  end

  // Serial decoder on tx_o; pops the scoreboard at each stop bit.
  always @(negedge pclk_i) begin
    if (!prst_ni) m_state = 0;
    else if (m_state == 0) begin
      if (tx_o == 1'b0) begin
        m_state = 1;
        m_cnt   = 0;
        tx_starts++;
        if (mark_start) begin start_cyc = cyc; mark_start = 1'b0; end
      end
    end else begin
      m_cnt++;
      if (m_cnt == CPB / 2) begin
        checks++;
        if (tx_o !== 1'b0) begin
          errors++;
          $display("FAIL tx_start: mid start bit tx_o=%b, required 0", tx_o);
        end
      end else if (m_cnt > CPB / 2 && m_cnt < CPB / 2 + 9 * CPB && (m_cnt - CPB / 2) % CPB == 0) begin
        m_sh = {tx_o, m_sh[7:1]};
      end else if (m_cnt == CPB / 2 + 9 * CPB) begin
        checks++;
        if (tx_o !== 1'b1) begin
          errors++;
          $display("FAIL tx_stop: stop bit tx_o=%b, required 1", tx_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %h, required no byte", m_sh);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_sh !== m_exp) begin
            errors++;
            $display("FAIL tx_byte: got %h, required %h", m_sh, m_exp);
          end
        end
        m_state = 0;
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx_i = 1'b0;
    repeat (CPB) @(negedge pclk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge pclk_i);
    end
    rx_i = good_stop;
    repeat (CPB) @(negedge pclk_i);
    rx_i = 1'b1;
    if (!good_stop) repeat (CPB) @(negedge pclk_i);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0 || m_state != 0) && n < 4000) begin
      @(negedge pclk_i);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL %s_done: %0d reply bytes pending busy_o=%b, required all sent and idle", name, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_reset;
    prst_ni = 1'b0;
    repeat (3) @(negedge pclk_i);
    prst_ni = 1'b1;
    repeat (2) @(negedge pclk_i);
    checks++;
    if ({tx_o, pwrite_o, pread_o, busy_o, err_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: {tx,pwrite,pread,busy,err}=%b, required 10000",
               {tx_o, pwrite_o, pread_o, busy_o, err_o});
    end
    checks++;
    if (paddr_o !== 12'h000 || pwdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h, required 000 00000000", paddr_o, pwdata_o);
    end
  endtask

  task automatic test_write(input string name, input logic [7:0] ahi, input logic [7:0] alo,
                            input logic [31:0] d, input logic [11:0] ea);
    int w0, r0, e0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    exp_q.push_back(8'h4B);
    mark_start = 1'b1;
    send_byte(8'h57, 1'b1);
    send_byte(ahi, 1'b1);
    send_byte(alo, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
    wait_done(name);
    checks++;
    if (wr_cnt - w0 != 1 || rd_cnt != r0) begin
      errors++;
      $display("FAIL %s_strobes: writes=%0d reads=%0d, required 1 0", name, wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (wr_addr !== ea) begin
      errors++;
      $display("FAIL %s_addr: got %h, required %h", name, wr_addr, ea);
    end
    checks++;
    if (wr_data !== d) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, wr_data, d);
    end
    checks++;
    if (start_cyc - wr_cyc != 1) begin
      errors++;
      $display("FAIL %s_latency: start bit %0d cycles after pwrite, required 1", name, start_cyc - wr_cyc);
    end
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL %s_err: %0d err pulses, required 0", name, err_cnt - e0);
    end
  endtask

  task automatic test_read(input string name, input logic [7:0] ahi, input logic [7:0] alo,
                           input logic [31:0] v, input logic [11:0] ea);
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    rd_val = v;
    for (int i = 3; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    mark_start = 1'b1;
    send_byte(8'h52, 1'b1);
    send_byte(ahi, 1'b1);
    send_byte(alo, 1'b1);
    wait_done(name);
    checks++;
    if (rd_cnt - r0 != 1 || wr_cnt != w0) begin
      errors++;
      $display("FAIL %s_strobes: reads=%0d writes=%0d, required 1 0", name, rd_cnt - r0, wr_cnt - w0);
    end
    checks++;
    if (rd_addr !== ea) begin
      errors++;
      $display("FAIL %s_addr: got %h, required %h", name, rd_addr, ea);
    end
    checks++;
    if (start_cyc - rd_cyc != 2) begin
      errors++;
      $display("FAIL %s_latency: start bit %0d cycles after pread, required 2", name, start_cyc - rd_cyc);
    end
  endtask

  task automatic test_bad_opcode;
    int w0, r0, e0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    exp_q.push_back(8'h45);
    send_byte(8'h13, 1'b1);
    wait_done("badop");
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL badop_err: %0d err cycles, required 1", err_cnt - e0);
    end
    checks++;
    if (wr_cnt != w0 || rd_cnt != r0) begin
      errors++;
      $display("FAIL badop_strobes: writes=%0d reads=%0d, required 0 0", wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_framing;
    int w0, r0, e0, s0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; s0 = tx_starts;
    send_byte(8'h57, 1'b1);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL frame_busy_mid: busy_o=%b, required 1", busy_o);
    end
    send_byte(8'h01, 1'b0);
    repeat (3 * CPB) @(negedge pclk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL frame_busy_drop: busy_o=%b, required 0", busy_o);
    end
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL frame_err: %0d err cycles, required 1", err_cnt - e0);
    end
    checks++;
    if (tx_starts != s0 || wr_cnt != w0 || rd_cnt != r0) begin
      errors++;
      $display("FAIL frame_quiet: tx bytes=%0d writes=%0d reads=%0d, required 0 0 0",
               tx_starts - s0, wr_cnt - w0, rd_cnt - r0);
    end
  endtask

  task automatic test_back_to_back;
    test_write("b2b_wr", 8'hF3, 8'h45, 32'hDEAD_BEEF, 12'h345);
    test_read("b2b_rd", 8'hA7, 8'hFF, 32'h0123_4567, 12'h7FF);
  endtask

  task automatic test_timeout;
    int e0, r0;
    e0 = err_cnt; r0 = rd_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (41 * CPB) @(negedge pclk_i);
`ifdef UART_BUS_TIMEOUT_EN
    checks++;
    if (err_cnt - e0 != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: err cycles=%0d busy_o=%b, required 1 0", err_cnt - e0, busy_o);
    end
    checks++;
    if (rd_cnt != r0) begin
      errors++;
      $display("FAIL tmo_strobes: reads=%0d, required 0", rd_cnt - r0);
    end
    test_read("tmo_after", 8'h00, 8'h08, 32'h5A5A_0FF0, 12'h008);
`else
    checks++;
    if (err_cnt != e0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: err cycles=%0d busy_o=%b, required 0 1", err_cnt - e0, busy_o);
    end
    rd_val = 32'h5A5A_0FF0;
    for (int i = 3; i >= 0; i--) exp_q.push_back(rd_val[i*8 +: 8]);
    send_byte(8'h08, 1'b1);
    wait_done("wait_rd");
    checks++;
    if (rd_cnt - r0 != 1 || rd_addr !== 12'h008) begin
      errors++;
      $display("FAIL wait_rd: reads=%0d addr=%h, required 1 008", rd_cnt - r0, rd_addr);
    end
`endif
  endtask

  task automatic test_reset_mid_tx;
    int n;
    rd_val = 32'hA5C3_1E77;
    for (int i = 3; i >= 0; i--) exp_q.push_back(rd_val[i*8 +: 8]);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h08, 1'b1);
    n = 0;
    while (!(m_state == 1 && m_cnt >= 40) && n < 1000) begin
      @(negedge pclk_i);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL rst_tx_wait: no reply in progress, required reply started");
    end
    // Bit 1 of 0xA5 is on the line: low.
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx_pre: tx_o=%b, required 0", tx_o);
    end
    #2 prst_ni = 1'b0;
    #1;
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx_async: tx_o=%b busy_o=%b, required 1 0", tx_o, busy_o);
    end
    exp_q.delete();
    repeat (4) @(negedge pclk_i);
    prst_ni = 1'b1;
    repeat (2) @(negedge pclk_i);
    test_read("rst_after", 8'h00, 8'h08, 32'hA5C3_1E77, 12'h008);
  endtask

  initial begin
    test_reset();
    test_write("write", 8'h00, 8'h0C, 32'h0000_0001, 12'h00C);
    test_read("read", 8'h00, 8'h08, 32'hA5C3_1E77, 12'h008);
    test_bad_opcode();
    test_framing();
    test_back_to_back();
    test_timeout();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
